// File: rtl/eth_phy_link_monitor_pkg.sv
// Shared types and default configuration for the PHY link monitor.
package eth_link_mon_pkg;

   localparam int unsigned STABLE_CYCLES_DEF       = 1024;
   localparam int unsigned LOCK_TIMEOUT_CYCLES_DEF = 1048576;
   localparam int unsigned RESET_PULSE_CYCLES_DEF  = 16;
   localparam int unsigned CNT_WIDTH_DEF           = 32;
   localparam int unsigned ERR_CNT_W               = 7;

   typedef enum logic [1:0] {
      ST_DOWN   = 2'd0,
      ST_STABLE = 2'd1,
      ST_UP     = 2'd2,
      ST_RESET  = 2'd3
   } link_state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/eth_phy_link_monitor_if.sv
// PHY status inputs and link/statistics outputs of the link monitor.
interface eth_phy_link_monitor_if #(
   parameter int unsigned CNT_WIDTH = eth_link_mon_pkg::CNT_WIDTH_DEF
) ();
   import eth_link_mon_pkg::*;

   logic                 rx_block_lock;
   logic                 rx_high_ber;
   logic [ERR_CNT_W-1:0] rx_error_count;
   logic                 rx_bad_block;
   logic                 rx_sequence_error;
   logic                 clear_counters;
   logic                 link_up;
   logic                 xcvr_rst_req;
   logic [CNT_WIDTH-1:0] err_total;
   logic [CNT_WIDTH-1:0] bad_block_total;
   logic [CNT_WIDTH-1:0] seq_err_total;
   logic [CNT_WIDTH-1:0] link_drop_total;

   modport master (
      output rx_block_lock, rx_high_ber, rx_error_count, rx_bad_block,
             rx_sequence_error, clear_counters,
      input  link_up, xcvr_rst_req, err_total, bad_block_total,
             seq_err_total, link_drop_total
   );

   modport slave (
      input  rx_block_lock, rx_high_ber, rx_error_count, rx_bad_block,
             rx_sequence_error, clear_counters,
      output link_up, xcvr_rst_req, err_total, bad_block_total,
             seq_err_total, link_drop_total
   );

endinterface

// File: rtl/eth_phy_link_monitor_sat_counter.sv
// Saturating accumulator with synchronous clear; clear beats the increment.
module eth_sat_counter #(
   parameter int unsigned W  = 32,
   parameter int unsigned IW = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clear,
   input  logic [IW-1:0] i_inc,
   output logic [W-1:0]  o_count
);

   localparam int unsigned SW = W + 1;

   logic [W-1:0] r_count;
   logic [W:0]   w_sum;

   assign w_sum = {1'b0, r_count} + SW'(i_inc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_count <= '0;
      else if (i_clear)  r_count <= '0;
      else if (w_sum[W]) r_count <= '1;
      else               r_count <= w_sum[W-1:0];
   end

   assign o_count = r_count;

endmodule

// File: rtl/eth_phy_link_monitor.sv
// PHY link qualification FSM plus saturating error statistics.
// Define ETH_LINK_MON_AUTORESET_EN to add the lock timeout and transceiver reset pulse.
module eth_phy_link_monitor
   import eth_link_mon_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES       = STABLE_CYCLES_DEF,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
   parameter int unsigned RESET_PULSE_CYCLES  = RESET_PULSE_CYCLES_DEF,
   parameter int unsigned CNT_WIDTH           = CNT_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   eth_phy_link_monitor_if.slave  bus
);

   localparam int unsigned SC_W = cnt_w(STABLE_CYCLES);

   link_state_t     r_state, w_next_state;
   logic [SC_W-1:0] r_stable_cnt, w_stable_cnt_nxt;
   logic            r_link_up;
   logic            w_good;
   logic            w_drop;

   assign w_good = bus.rx_block_lock & ~bus.rx_high_ber;
   assign w_drop = (r_state == ST_UP) & ~w_good;

`ifdef ETH_LINK_MON_AUTORESET_EN
   localparam int unsigned TO_W = cnt_w(LOCK_TIMEOUT_CYCLES);
   localparam int unsigned PW   = cnt_w(RESET_PULSE_CYCLES);

   logic [TO_W-1:0] r_timer, w_timer_nxt;
   logic [PW-1:0]   r_pulse_cnt, w_pulse_nxt;
   logic            r_xcvr_rst_req;
`endif

   // Next-state and counter updates
   always_comb begin
      w_next_state     = r_state;
      w_stable_cnt_nxt = r_stable_cnt;
`ifdef ETH_LINK_MON_AUTORESET_EN
      w_timer_nxt      = r_timer;
      w_pulse_nxt      = r_pulse_cnt;
`endif
      case (r_state)
         ST_DOWN: begin
            if (w_good) begin
               w_next_state     = ST_STABLE;
               w_stable_cnt_nxt = '0;
            end
         end
         ST_STABLE: begin
            if (!w_good)
               w_next_state = ST_DOWN;
            else if (r_stable_cnt == SC_W'(STABLE_CYCLES - 1))
               w_next_state = ST_UP;
            else
               w_stable_cnt_nxt = r_stable_cnt + 1'b1;
         end
         ST_UP: begin
            if (!w_good) w_next_state = ST_DOWN;
         end
         default: begin
`ifdef ETH_LINK_MON_AUTORESET_EN
            if (r_pulse_cnt == PW'(RESET_PULSE_CYCLES - 1))
               w_next_state = ST_DOWN;
            else
               w_pulse_nxt = r_pulse_cnt + 1'b1;
`else
            w_next_state = ST_DOWN;
`endif
         end
      endcase
`ifdef ETH_LINK_MON_AUTORESET_EN
      // Timeout overrides any qualification progress made this cycle
      if (r_state == ST_DOWN || r_state == ST_STABLE) begin
         if (r_timer == TO_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
            w_next_state = ST_RESET;
            w_timer_nxt  = '0;
            w_pulse_nxt  = '0;
         end else begin
            w_timer_nxt  = r_timer + 1'b1;
         end
      end
      if (w_next_state == ST_UP) w_timer_nxt = '0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_DOWN;
         r_stable_cnt <= '0;
         r_link_up    <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_stable_cnt <= w_stable_cnt_nxt;
         r_link_up    <= (w_next_state == ST_UP);
      end
   end

`ifdef ETH_LINK_MON_AUTORESET_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer        <= '0;
         r_pulse_cnt    <= '0;
         r_xcvr_rst_req <= 1'b0;
      end else begin
         r_timer        <= w_timer_nxt;
         r_pulse_cnt    <= w_pulse_nxt;
         r_xcvr_rst_req <= (w_next_state == ST_RESET);
      end
   end

   assign bus.xcvr_rst_req = r_xcvr_rst_req;
`else
   logic w_unused_cfg;
   assign w_unused_cfg     = ^{LOCK_TIMEOUT_CYCLES, RESET_PULSE_CYCLES};
   assign bus.xcvr_rst_req = 1'b0;
`endif

   assign bus.link_up = r_link_up;

   eth_sat_counter #(.W(CNT_WIDTH), .IW(ERR_CNT_W)) u_err_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (bus.clear_counters),
      .i_inc   (bus.rx_error_count),
      .o_count (bus.err_total)
   );

   eth_sat_counter #(.W(CNT_WIDTH), .IW(1)) u_bad_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (bus.clear_counters),
      .i_inc   (bus.rx_bad_block),
      .o_count (bus.bad_block_total)
   );

   eth_sat_counter #(.W(CNT_WIDTH), .IW(1)) u_seq_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (bus.clear_counters),
      .i_inc   (bus.rx_sequence_error),
      .o_count (bus.seq_err_total)
   );

   eth_sat_counter #(.W(CNT_WIDTH), .IW(1)) u_drop_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (bus.clear_counters),
      .i_inc   (w_drop),
      .o_count (bus.link_drop_total)
   );

endmodule

// File: doc/eth_phy_link_monitor.md
ETH_PHY_LINK_MONITOR -- requirements
Module: eth_phy_link_monitor

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 1024: consecutive good-lock cycles required before link_up asserts.
REQ-002 The block SHALL have parameter LOCK_TIMEOUT_CYCLES, default 1048576: cycles without reaching UP before an auto-reset request is issued.
REQ-003 The block SHALL have parameter RESET_PULSE_CYCLES, default 16: width of xcvr_rst_req in cycles.
REQ-004 The block SHALL have parameter CNT_WIDTH, default 32: width of each statistics counter.
REQ-005 The block SHALL have the port clk, input, 1, PHY RX clock (phy_rx_clk domain); it is the block's only clock.
REQ-006 The block SHALL have the port rst_n, input, 1, reset; it is asynchronous and active-low.
REQ-007 The block SHALL have the port rx_block_lock, input, 1, PHY block lock.
REQ-008 The block SHALL have the port rx_high_ber, input, 1, PHY high-BER flag.
REQ-009 The block SHALL have the port rx_error_count, input, 7, per-cycle PHY error count.
REQ-010 The block SHALL have the port rx_bad_block, input, 1, per-cycle bad-block strobe.
REQ-011 The block SHALL have the port rx_sequence_error, input, 1, per-cycle sequence-error strobe.
REQ-012 The block SHALL have the port clear_counters, input, 1, synchronous clear of all statistics counters.
REQ-013 The block SHALL have the port link_up, output, 1, qualified link status.
REQ-014 The block SHALL have the port xcvr_rst_req, output, 1, transceiver reset request (drives xcvr_ctrl_rst via OR).
REQ-015 The block SHALL have the ports err_total, bad_block_total, seq_err_total and link_drop_total, each output, CNT_WIDTH, saturating statistics.

Function
REQ-016 A cycle SHALL be "good" when rx_block_lock=1 and rx_high_ber=0.
REQ-017 The FSM SHALL have the states DOWN, STABLE, UP and RESET.
REQ-018 In DOWN, a good cycle SHALL move the FSM to STABLE with stable_cnt=0.
REQ-019 In STABLE, a non-good cycle SHALL move the FSM to DOWN.
REQ-020 In STABLE, a good cycle with stable_cnt=STABLE_CYCLES-1 SHALL move the FSM to UP; any other good cycle SHALL increment stable_cnt.
REQ-021 link_up SHALL be registered and equal (state==UP), rising on the STABLE_CYCLES-th edge after the edge that entered STABLE.
REQ-022 In UP, a non-good cycle SHALL move the FSM to DOWN, deassert link_up on that edge and increment link_drop_total by 1.
REQ-023 Each cycle, err_total SHALL add the zero-extended rx_error_count, bad_block_total SHALL add rx_bad_block, and seq_err_total SHALL add rx_sequence_error, in every state.
REQ-024 All counters SHALL saturate at all-ones and never wrap; an add that would overflow SHALL yield all-ones.
REQ-025 If clear_counters and an increment occur in the same cycle, clear SHALL win: the counter becomes 0 and that cycle's increment is dropped.
REQ-026 clear_counters SHALL NOT affect the FSM, stable_cnt or the timeout timer.
REQ-027 There SHALL be no handshake; all inputs SHALL be sampled every cycle.

Reset
REQ-028 While rst_n=0, the block SHALL hold state=DOWN, link_up=0, xcvr_rst_req=0, and all counters, stable_cnt and timers at 0.
REQ-029 Deassertion of rst_n mid-operation SHALL restart from DOWN with no pending pulse.

Configuration
REQ-030 With macro ETH_LINK_MON_AUTORESET_EN defined, a timeout timer SHALL count every cycle in DOWN or STABLE and clear on entering UP.
REQ-031 With ETH_LINK_MON_AUTORESET_EN defined, when the timer reaches LOCK_TIMEOUT_CYCLES-1 the FSM SHALL enter RESET, assert xcvr_rst_req for exactly RESET_PULSE_CYCLES cycles ignoring inputs, then return to DOWN with the timer at 0.
REQ-032 Without ETH_LINK_MON_AUTORESET_EN, the RESET state and the timer SHALL be absent, xcvr_rst_req SHALL be tied to 0, and LOCK_TIMEOUT_CYCLES and RESET_PULSE_CYCLES SHALL be unused.

Structure
REQ-033 Package eth_link_mon_pkg SHALL hold the FSM state typedef and the default parameter constants.
REQ-034 Saturating add-with-clear SHALL be a sub-module named eth_sat_counter, instantiated four times.

Verification (STABLE_CYCLES=16, LOCK_TIMEOUT_CYCLES=100, RESET_PULSE_CYCLES=4, CNT_WIDTH=8)
REQ-035 The bench SHALL hold lock=1, ber=0 from reset release and check that link_up rises exactly 16 edges after STABLE entry.
REQ-036 The bench SHALL drop lock for 1 cycle at stable_cnt=10 and check a return to DOWN, link_up still 0 and link_drop_total=0; then drop lock in UP and check link_up=0 next edge and link_drop_total=1.
REQ-037 The bench SHALL drive rx_error_count=127 for 3 cycles and check err_total=255 (saturated), then assert clear_counters with bad_block=1 and check bad_block_total=0.
REQ-038 With ETH_LINK_MON_AUTORESET_EN defined and lock=0, the bench SHALL check xcvr_rst_req high for exactly 4 cycles starting after edge 100, then a return to DOWN and a repeat every 104 cycles.
REQ-039 The bench SHALL assert rst_n=0 during UP and during a RESET pulse and check that all outputs are 0 immediately (asynchronously).
